// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter : single-port SRAM shared by NPORTS requesters, one access/cycle
//   Fixed priority by default; SRAM_ARBITER_ROUND_ROBIN_EN selects round-robin.
// Revision: 1.0
// ============================================================================
module sram_arbiter #(
    parameter int NPORTS = 3,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*DW-1:0] wdata,
    output logic [NPORTS-1:0]    rdy,
    output logic [DW-1:0]        rdata,
    output logic [2:0]           gnt_id
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]     mem [DEPTH];
    logic [NPORTS-1:0] eligible;
    logic [7:0]        elig8;
    logic              grant_valid;
    logic [2:0]        grant_idx;
    logic [NPORTS-1:0] grant_vec;
    logic [IW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic              sel_we;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    // ptr holds the first index to search: one above the last granted port
    logic [2:0]        ptr;
    logic [3:0]        cand;
`endif

    // Upper address bits alias onto the same word by design
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    always_comb begin
        eligible    = req & ~rdy;
        elig8       = 8'(eligible);
        grant_valid = 1'b0;
        grant_idx   = '0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
        cand        = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = 4'(ptr) + 4'(k);
            if (cand >= 4'(NPORTS)) begin
                cand = cand - 4'(NPORTS);
            end
            if (!grant_valid && elig8[cand[2:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
`else
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (elig8[k]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(k);
            end
        end
`endif
        grant_valid = grant_valid && reset_n;

        grant_vec = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (grant_valid && grant_idx == 3'(k)) begin
                grant_vec[k] = 1'b1;
                sel_addr     = addr[k*AW +: IW];
                sel_wdata    = wdata[k*DW +: DW];
                sel_we       = we[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy    <= '0;
            rdata  <= '0;
            gnt_id <= '0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
            ptr    <= '0;
`endif
        end else begin
            rdy <= grant_vec;
            if (grant_valid) begin
                gnt_id <= grant_idx;
                if (!sel_we) begin
                    rdata <= mem[sel_addr];
                end
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
                if (grant_idx == 3'(NPORTS - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx + 3'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_valid && sel_we) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

endmodule
`default_nettype wire
